// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, a status register and a programmable baud divisor.
// Read data is registered (one-cycle latency) and is zero for unselected addresses, so it can be OR-merged.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_WORD       = 32'h42,
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  wr_en,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        tx,
  output logic        tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [15:0]   frame_div_q, frame_div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   divisor_q, divisor_d;
  logic [31:0]   data_out_q, data_out_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];

  logic sel_data, sel_status, sel_div;
  logic push_req, push_acc, pop, baud_done, busy, fifo_empty, fifo_full;
  logic [15:0] div_eff;
  logic unused_bits;

  assign sel_data    = (addr == BASE_WORD);
  assign sel_status  = (addr == BASE_WORD + 32'd1);
  assign sel_div     = (addr == BASE_WORD + 32'd2);
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == DEPTH_C);
  assign push_req    = sel_data & wr_en[0];
  // A full FIFO still accepts a byte when the transmitter frees a slot in the same cycle.
  assign push_acc    = push_req & (~fifo_full | pop);
  assign div_eff     = (divisor_q == 16'd0) ? 16'd1 : divisor_q;
  assign baud_done   = (baud_q == frame_div_q - 16'd1);
  assign unused_bits = ^{data_in[31:16], wr_en[3:2]};

  // State register and all other flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      frame_div_q <= 16'd1;
      bit_q       <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      divisor_q   <= DEFAULT_DIVISOR;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      frame_div_q <= frame_div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      divisor_q   <= divisor_d;
      data_out_q  <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) fifo_q[wr_ptr_q] <= data_in[7:0];
  end

  // Next-state logic for the transmit FSM; the divisor is captured when a byte is popped.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    frame_div_d = frame_div_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          state_d     = S_START;
          shift_d     = fifo_q[rd_ptr_q];
          frame_div_d = div_eff;
          baud_d      = '0;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop         = 1'b1;
            state_d     = S_START;
            shift_d     = fifo_q[rd_ptr_q];
            frame_div_d = div_eff;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping and register writes
  always_comb begin
    wr_ptr_d   = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push_acc && !pop) count_d = count_q + CW'(1);
    if (!push_acc && pop) count_d = count_q - CW'(1);
    overflow_d = overflow_q;
    if (push_req && !push_acc) overflow_d = 1'b1;
    else if (sel_status && wr_en[0] && data_in[3]) overflow_d = 1'b0;
    divisor_d  = divisor_q;
    if (sel_div && wr_en[0]) divisor_d[7:0]  = data_in[7:0];
    if (sel_div && wr_en[1]) divisor_d[15:8] = data_in[15:8];
    data_out_d = '0;
    if (sel_status)
      data_out_d = {16'h0, 8'(count_q), 4'h0, overflow_q, busy, fifo_empty, fifo_full};
    else if (sel_div)
      data_out_d = {16'h0, divisor_q};
  end

  // Output logic
  always_comb begin
    tx = 1'b1;
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
    busy    = (state_q != S_IDLE);
    tx_done = ~busy & fifo_empty;
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register reads checked directly, serial frames checked by a monitor
// against a queue of expected {divisor, byte} entries.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX  = 32'h42;
  localparam logic [31:0] A_ST  = 32'h43;
  localparam logic [31:0] A_DIV = 32'h44;
  localparam logic [31:0] A_UNM = 32'h40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = A_UNM;
  logic [3:0]  wr_en = 4'h0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        tx;
  logic        tx_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b1;
  logic [23:0] exp_q[$];

  mmio_uart_tx dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .data_out (data_out),
    .tx       (tx),
    .tx_done  (tx_done)
  );

  // Clock / cycle counter / global timeout
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Driver tasks
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    addr = a; wr_en = be; data_in = d;
    @(posedge clk); #1;
    addr = A_UNM; wr_en = 4'h0; data_in = 32'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; wr_en = 4'h0;
    @(posedge clk); #1;
    d = data_out;
    addr = A_UNM;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check32(name, d, exp);
  endtask

  task automatic push_byte(input logic [15:0] div, input logic [7:0] b);
    exp_q.push_back({div, b});
    bus_write(A_TX, 4'b0001, {24'h0, b});
  endtask

  task automatic wait_done(input int budget);
    int guard = 0;
    while (tx_done !== 1'b1 && guard < budget) begin
      @(posedge clk); #1;
      guard++;
    end
  endtask

  // Scoreboard monitor: on a start bit, pop the expected frame and check every sample of it.
  initial begin
    logic [23:0] e;
    logic [9:0]  bits;
    logic [9:0]  rx;
    int          div;
    int          bad;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: tx went low with no byte expected");
          while (tx === 1'b0) @(negedge clk);
        end else begin
          e    = exp_q.pop_front();
          div  = int'(e[23:8]);
          bits = {1'b1, e[7:0], 1'b0};
          rx   = '0;
          bad  = 0;
          for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < div; j++) begin
              if (!(k == 0 && j == 0)) @(negedge clk);
              if (j == div / 2) rx[k] = tx;
              if (tx !== bits[k]) bad++;
            end
          end
          checks++;
          if (bad != 0) begin
            errors++;
            $display("FAIL frame: rx byte %h (start %b stop %b) expected %h at div %0d, bad samples %0d",
                     rx[8:1], rx[0], rx[9], e[7:0], div, bad);
          end
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int t0;
    int lows;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check32("reset_tx", {31'h0, tx}, 32'h1);
    check32("reset_tx_done", {31'h0, tx_done}, 32'h1);
    read_check("reset_status", A_ST, 32'h0000_0002);
    read_check("reset_divisor", A_DIV, 32'd868);
    read_check("unmapped_read", A_UNM, 32'h0);
    read_check("txdata_read", A_TX, 32'h0);

    // Unmapped write has no effect; divisor upper bits read zero
    bus_write(A_UNM, 4'hF, 32'hFFFF_FFFF);
    read_check("unmapped_wr_status", A_ST, 32'h0000_0002);
    read_check("unmapped_wr_divisor", A_DIV, 32'd868);
    bus_write(A_DIV, 4'hF, 32'hABCD_0004);
    read_check("divisor_upper_zero", A_DIV, 32'h0000_0004);

    // Single byte 0x55 at divisor 4, with status latency
    push_byte(16'd4, 8'h55);
    t0 = cyc;
    read_check("status_after_push", A_ST, 32'h0000_0100);
    read_check("status_busy", A_ST, 32'h0000_0006);
    wait_done(200);
    check32("single_frame_len", 32'(cyc - t0), 32'd41);
    read_check("status_idle", A_ST, 32'h0000_0002);

    // Overflow with 10 back-to-back writes at divisor 100
    bus_write(A_DIV, 4'b0011, 32'd100);
    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back({16'd100, 8'(i)});
      bus_write(A_TX, 4'b0001, 32'(i));
      if (i == 0) t0 = cyc;
    end
    read_check("status_overflow", A_ST, 32'h0000_080D);
    bus_write(A_ST, 4'b0001, 32'h8);
    read_check("status_ovf_cleared", A_ST, 32'h0000_0805);
    read_check("unmapped_busy", A_UNM, 32'h0);
    wait_done(12000);
    check32("burst_len", 32'(cyc - t0), 32'd9001);
    check32("burst_tx_done", {31'h0, tx_done}, 32'h1);

    // Divisor change mid-frame affects only the next frame
    bus_write(A_DIV, 4'b0011, 32'd4);
    push_byte(16'd4, 8'hA3);
    t0 = cyc;
    repeat (5) begin @(posedge clk); #1; end
    bus_write(A_DIV, 4'b0011, 32'd8);
    push_byte(16'd8, 8'h3C);
    wait_done(500);
    check32("div_change_len", 32'(cyc - t0), 32'd121);

    // Divisor 0 behaves as 1
    bus_write(A_DIV, 4'b0011, 32'd0);
    push_byte(16'd1, 8'hF0);
    t0 = cyc;
    wait_done(100);
    check32("div_zero_len", 32'(cyc - t0), 32'd11);

    // Reset during DATA aborts the frame and empties the FIFO
    mon_en = 1'b0;
    bus_write(A_DIV, 4'b0011, 32'd4);
    bus_write(A_TX, 4'b0001, 32'h00);
    bus_write(A_TX, 4'b0001, 32'h11);
    repeat (8) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check32("midreset_tx", {31'h0, tx}, 32'h1);
    check32("midreset_tx_done", {31'h0, tx_done}, 32'h1);
    read_check("midreset_status", A_ST, 32'h0000_0002);
    read_check("midreset_divisor", A_DIV, 32'd868);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check32("midreset_no_frame", 32'(lows), 32'd0);
    read_check("unmapped_final", A_UNM, 32'h0);
    mon_en = 1'b1;

    check32("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
